pipeline_ctrl: RTL and testbench

//   Pipeline controller for the 5-stage MIPS32 core. Merges per-stage stall requests into
//   the stall[5:0] vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and
//   MEM/WB latches. Sequences exception entry and ERET: freezes the pipe, then issues a
//   one-cycle flush with the handler or return address for the PC register.

---
 rtl/pipeline_ctrl_if.sv | 25 ++
 rtl/pipeline_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Stage-side handshake bundle for the pipeline controller: per-stage stall
// requests and exception info in, stall vector and PC redirect out.
interface pipeline_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// MIPS32 5-stage pipeline controller: merges stall requests, sequences
// exception/ERET flush with PC redirect, and keeps stall statistics plus a watchdog.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hbfc00380,
    parameter int          CNT_W         = 32,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              stall_timeout
);

    localparam int              WD_W     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(STALL_TIMEOUT);
    localparam logic [31:0]     EXC_ERET = 32'h0000000e;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e            state_q, state_d;
    logic              flush_q, flush_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    logic              exc_c;
    logic [5:0]        stall_c;

    // Stall is purely combinational so the stage latches hold in the same cycle.
    always_comb begin
        exc_c   = (bus.excepttype_i != 32'h0);
        stall_c = 6'b000000;
        if (rst && state_q == RUN) begin
            if (exc_c)                 stall_c = 6'b111111;
            else if (bus.stallreq_mem) stall_c = 6'b011111;
            else if (bus.stallreq_ex)  stall_c = 6'b001111;
            else if (bus.stallreq_id)  stall_c = 6'b000111;
            else if (bus.stallreq_if)  stall_c = 6'b000011;
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_d        = flush_q;
        new_pc_d       = new_pc_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        wdog_d         = wdog_q;
        timeout_d      = timeout_q;

        case (state_q)
            RUN: begin
                if (exc_c) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
                    if (!(&flush_count_q)) flush_count_d = flush_count_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                // Inputs this cycle belong to squashed instructions.
                state_d = RUN;
                flush_d = 1'b0;
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
        endcase

        if (stall_c != 6'b000000 && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);

        if (state_q == RUN && stall_c != 6'b000000) begin
            if (wdog_q != WD_MAX) wdog_d = wdog_q + WD_W'(1);
        end else begin
            wdog_d = '0;
        end
        if (wdog_d == WD_MAX) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RUN;
            flush_q        <= 1'b0;
            new_pc_q       <= 32'h0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_q        <= flush_d;
            new_pc_q       <= new_pc_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            wdog_q         <= wdog_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.flush     = flush_q;
    assign bus.new_pc    = new_pc_q;
    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table with a scoreboard for the registered
// flush/new_pc, plus directed watchdog, saturation and reset-in-flush sequences.
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             stall_timeout;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(
        .EXC_VECTOR    (32'hbfc00380),
        .CNT_W         (CNT_W),
        .STALL_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;        // {mem, ex, id, if}
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  exp_stall;
        logic        exp_flush;  // registered result after this row's edge
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
        bus.stallreq_mem = req[3];
        bus.stallreq_ex  = req[2];
        bus.stallreq_id  = req[1];
        bus.stallreq_if  = req[0];
        bus.excepttype_i = exc;
        bus.cp0_epc_i    = epc;
    endtask

    task automatic sb_pop_check(input string name);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got flush=%0b new_pc=%h", name, bus.flush, bus.new_pc);
        end else begin
            e = sb_q.pop_front();
            if (bus.flush !== e.flush || bus.new_pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s: got flush=%0b new_pc=%h expected flush=%0b new_pc=%h",
                         name, bus.flush, bus.new_pc, e.flush, e.pc);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e0;
        //          req      exc           epc           stall      fl   pc
        vecs[0]  = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'h0};
        vecs[1]  = '{4'b0110, 32'h0,    32'h0,        6'b001111, 1'b0, 32'h0};
        vecs[2]  = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'h0};
        vecs[3]  = '{4'b0001, 32'h0,    32'h0,        6'b000011, 1'b0, 32'h0};
        vecs[4]  = '{4'b0010, 32'h0,    32'h0,        6'b000111, 1'b0, 32'h0};
        vecs[5]  = '{4'b1001, 32'h0,    32'h0,        6'b011111, 1'b0, 32'h0};
        vecs[6]  = '{4'b0000, 32'h8,    32'h0,        6'b111111, 1'b1, 32'hbfc00380};
        vecs[7]  = '{4'b1000, 32'h1,    32'h0,        6'b000000, 1'b0, 32'hbfc00380};
        vecs[8]  = '{4'b1000, 32'he,    32'hbfc00124, 6'b111111, 1'b1, 32'hbfc00124};
        vecs[9]  = '{4'b1000, 32'he,    32'hbfc00124, 6'b000000, 1'b0, 32'hbfc00124};
        vecs[10] = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'hbfc00124};
        vecs[11] = '{4'b0100, 32'hc,    32'h12345678, 6'b111111, 1'b1, 32'hbfc00380};
        vecs[12] = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'hbfc00380};
        vecs[13] = '{4'b0000, 32'h1,    32'h0,        6'b111111, 1'b1, 32'hbfc00380};
        vecs[14] = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'hbfc00380};
        vecs[15] = '{4'b0000, 32'h1234, 32'hdeadbeef, 6'b111111, 1'b1, 32'hbfc00380};
        vecs[16] = '{4'b0000, 32'h0,    32'h0,        6'b000000, 1'b0, 32'hbfc00380};

        // Reset: stall forced to zero even with an exception and MEM stall present.
        rst = 1'b0;
        drive(4'b1000, 32'h8, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",   32'(bus.stall), 32'h0);
        chk("rst_flush",   32'(bus.flush), 32'h0);
        chk("rst_new_pc",  bus.new_pc, 32'h0);
        chk("rst_scycles", 32'(stall_cycles), 32'h0);
        chk("rst_fcount",  32'(flush_count), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);

        @(posedge clk); #1;
        rst = 1'b1;
        drive(4'b0000, 32'h0, 32'h0);
        e0.flush = 1'b0;
        e0.pc    = 32'h0;
        sb_q.push_back(e0);

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(posedge clk); #1;
            drive(vecs[i].req, vecs[i].exc, vecs[i].epc);
            @(negedge clk);
            sb_pop_check($sformatf("v%0d_reg", i));
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            e.flush = vecs[i].exp_flush;
            e.pc    = vecs[i].exp_pc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        drive(4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        sb_pop_check("vend_reg");
        chk("tbl_scycles", 32'(stall_cycles), 32'd9);
        chk("tbl_fcount",  32'(flush_count), 32'd5);
        chk("tbl_timeout", 32'(stall_timeout), 32'h0);

        // Watchdog: 8 consecutive ID stalls set the sticky timeout.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(4'b0010, 32'h0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 7) chk("wd_before", 32'(stall_timeout), 32'h0);
        end
        chk("wd_set",      32'(stall_timeout), 32'h1);
        chk("wd_scycles",  32'(stall_cycles), 32'd8);
        chk("wd_stall",    32'(bus.stall), 32'(6'b000111));
        drive(4'b0000, 32'h0, 32'h0);
        repeat (3) @(posedge clk); #1;
        chk("wd_sticky",   32'(stall_timeout), 32'h1);
        chk("wd_nostall",  32'(bus.stall), 32'h0);
        drive(4'b0010, 32'h0, 32'h0);
        repeat (12) @(posedge clk); #1;
        chk("sat_scycles", 32'(stall_cycles), 32'hf);
        chk("sat_fcount",  32'(flush_count), 32'h0);
        drive(4'b0000, 32'h0, 32'h0);

        // Reset asserted during the FLUSH cycle.
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_clr_timeout", 32'(stall_timeout), 32'h0);
        rst = 1'b1;
        drive(4'b0000, 32'h8, 32'h0);
        @(posedge clk); #1;
        chk("rf_flush",    32'(bus.flush), 32'h1);
        chk("rf_new_pc",   bus.new_pc, 32'hbfc00380);
        chk("rf_fcount",   32'(flush_count), 32'h1);
        rst = 1'b0;
        drive(4'b1000, 32'h8, 32'h0);
        @(negedge clk);
        chk("rf_stall_rst", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        chk("rf_flush_clr",  32'(bus.flush), 32'h0);
        chk("rf_new_pc_clr", bus.new_pc, 32'h0);
        chk("rf_fcount_clr", 32'(flush_count), 32'h0);
        chk("rf_scyc_clr",   32'(stall_cycles), 32'h0);
        rst = 1'b1;
        drive(4'b0000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("rf_no_2nd_flush", 32'(bus.flush), 32'h0);
        chk("rf_fcount_after", 32'(flush_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
